// File: rtl/rom_loader.sv
// Framed byte-stream loader for the 23256 ROM emulator's backing RAM: {len_hi, len_lo, payload[N], csum}.
// Optional inter-byte timeout is built only when LOADER_TIMEOUT_EN is defined.
module rom_loader #(
   parameter int ADDR_W         = 15,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rom_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       byte_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   // Largest legal frame fills the whole RAM exactly once.
   localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

   state_t              r_state;
   state_t              w_next;
   logic                r_in_ready;
   logic                r_busy;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic                r_done;
   logic                r_error;
   logic [15:0]         r_byte_count;
   logic [15:0]         r_len;
   logic [DATA_W-1:0]   r_sum;

   logic                w_accept;
   logic                w_start_ok;
   logic                w_busy_next;
   logic                w_last_byte;
   logic                w_csum_ok;
   logic                w_timeout;
   logic [16:0]         w_len_ext;
   logic [DATA_W-1:0]   w_sum_next;

   assign w_accept    = in_valid && r_in_ready;
   assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
   assign w_len_ext   = {1'b0, r_len[15:8], in_data[7:0]};
   assign w_sum_next  = r_sum + in_data;
   assign w_csum_ok   = (w_sum_next == '0);
   assign w_last_byte = ((r_byte_count + 16'd1) == r_len);

`ifdef LOADER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_idle_cnt;

   assign w_timeout = r_busy && !w_accept && (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_idle_cnt <= '0;
      else if (!r_busy || w_accept || w_timeout)
         r_idle_cnt <= '0;
      else
         r_idle_cnt <= r_idle_cnt + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
         S_LEN_HI:              if (w_accept) w_next = S_LEN_LO;
         S_LEN_LO: begin
            if (w_accept) begin
               if (w_len_ext > MAX_LEN)  w_next = S_ERR;
               else if (w_len_ext == '0) w_next = S_CSUM;
               else                      w_next = S_DATA;
            end
         end
         S_DATA:                if (w_accept && w_last_byte) w_next = S_CSUM;
         S_CSUM:                if (w_accept) w_next = w_csum_ok ? S_DONE : S_ERR;
         default:               w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_ERR;
   end

   assign w_busy_next = (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                        (w_next == S_DATA)   || (w_next == S_CSUM);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_byte_count <= '0;
         r_len        <= '0;
         r_sum        <= '0;
      end else begin
         r_wr_en    <= 1'b0;
         r_in_ready <= w_busy_next;
         r_busy     <= w_busy_next;

         if (w_start_ok) begin
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_byte_count <= '0;
            r_sum        <= '0;
            r_wr_addr    <= '0;
         end

         if (w_accept) begin
            unique case (r_state)
               S_LEN_HI: r_len[15:8] <= in_data[7:0];
               S_LEN_LO: r_len[7:0]  <= in_data[7:0];
               S_DATA: begin
                  // Byte k lands at address k, one cycle after its handshake.
                  r_wr_en      <= 1'b1;
                  r_wr_addr    <= r_byte_count[ADDR_W-1:0];
                  r_wr_data    <= in_data;
                  r_sum        <= w_sum_next;
                  r_byte_count <= r_byte_count + 16'd1;
               end
               default: ;
            endcase
         end

         if (r_state == S_CSUM && w_next == S_DONE)
            r_done <= 1'b1;
         if (r_state != S_ERR && w_next == S_ERR)
            r_error <= 1'b1;
      end
   end

   assign in_ready   = r_in_ready;
   assign busy       = r_busy;
   assign rom_hold   = r_busy;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign done       = r_done;
   assign error      = r_error;
   assign byte_count = r_byte_count;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: framing, checksum, length limits, write latency and async reset.
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rom_hold;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] byte_count;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;
   wr_t wr_log[$];

   rom_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rom_hold   (rom_hold),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer one byte and return 1 ns after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL send_byte_timeout: in_ready=%0b required=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #12;
      n_total++;
      if ({in_ready, wr_en, wr_addr, wr_data, rom_hold, busy, done, error, byte_count} !== 45'd0)
         $display("FAIL reset_outputs: rdy=%0b we=%0b a=%h d=%h hold=%0b busy=%0b done=%0b err=%0b cnt=%0d required all 0",
                  in_ready, wr_en, wr_addr, wr_data, rom_hold, busy, done, error, byte_count);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_good_frame();
      wr_log.delete();
      // start and a byte arrive together in IDLE; the byte must not be consumed
      start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      tick();
      start = 1'b0; in_valid = 1'b0;
      n_total++;
      if ({busy, rom_hold, in_ready, done, error} !== 5'b11100)
         $display("FAIL good_enter_len_hi: busy/hold/rdy/done/err=%b required 11100", {busy, rom_hold, in_ready, done, error});
      else n_pass++;
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h11);
      n_total++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 15'd0, 8'h11})
         $display("FAIL good_write0: we=%0b addr=%h data=%h required 1/0000/11", wr_en, wr_addr, wr_data);
      else n_pass++;
      send_byte(8'h22);
      n_total++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 15'd1, 8'h22})
         $display("FAIL good_write1: we=%0b addr=%h data=%h required 1/0001/22", wr_en, wr_addr, wr_data);
      else n_pass++;
      send_byte(8'h33);
      n_total++;
      if ({wr_en, wr_addr, wr_data, busy, rom_hold} !== {1'b1, 15'd2, 8'h33, 1'b1, 1'b1})
         $display("FAIL good_write2_drain: we=%0b addr=%h data=%h busy=%0b hold=%0b required 1/0002/33/1/1",
                  wr_en, wr_addr, wr_data, busy, rom_hold);
      else n_pass++;
      send_byte(8'h9A);
      n_total++;
      if ({done, error, busy, rom_hold, in_ready, wr_en, byte_count} !== {6'b100000, 16'd3})
         $display("FAIL good_done: done=%0b err=%0b busy=%0b hold=%0b rdy=%0b we=%0b cnt=%0d required 1/0/0/0/0/0/3",
                  done, error, busy, rom_hold, in_ready, wr_en, byte_count);
      else n_pass++;
      n_total++;
      if ({wr_addr, wr_data, 32'(wr_log.size())} !== {15'd2, 8'h33, 32'd3})
         $display("FAIL good_hold_and_count: addr=%h data=%h writes=%0d required 0002/33/3", wr_addr, wr_data, wr_log.size());
      else n_pass++;
   endtask

   task automatic test_bad_csum();
      wr_log.delete();
      do_start();
      n_total++;
      if ({done, error, byte_count} !== 18'd0)
         $display("FAIL badcs_clear: done=%0b err=%0b cnt=%0d required 0/0/0", done, error, byte_count);
      else n_pass++;
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h11);
      // start while busy must be ignored
      do_start();
      n_total++;
      if ({busy, wr_en, byte_count} !== {2'b10, 16'd1})
         $display("FAIL badcs_start_ignored: busy=%0b we=%0b cnt=%0d required 1/0/1", busy, wr_en, byte_count);
      else n_pass++;
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h9B);
      n_total++;
      if ({done, error, busy, rom_hold, byte_count, 32'(wr_log.size())} !== {4'b0100, 16'd3, 32'd3})
         $display("FAIL badcs_error: done=%0b err=%0b busy=%0b hold=%0b cnt=%0d writes=%0d required 0/1/0/0/3/3",
                  done, error, busy, rom_hold, byte_count, wr_log.size());
      else n_pass++;
      n_total++;
      if (wr_log.size() != 3 || wr_log[1] !== {15'd1, 8'h22})
         $display("FAIL badcs_write1: writes=%0d required second write 0001/22", wr_log.size());
      else n_pass++;
   endtask

   task automatic test_bad_len();
      wr_log.delete();
      do_start();
      send_byte(8'h80);
      n_total++;
      if ({busy, error} !== 2'b10)
         $display("FAIL badlen_mid: busy=%0b err=%0b required 1/0", busy, error);
      else n_pass++;
      send_byte(8'h01);
      n_total++;
      if ({error, done, busy, rom_hold, in_ready, 32'(wr_log.size())} !== {5'b10000, 32'd0})
         $display("FAIL badlen_err: err=%0b done=%0b busy=%0b hold=%0b rdy=%0b writes=%0d required 1/0/0/0/0/0",
                  error, done, busy, rom_hold, in_ready, wr_log.size());
      else n_pass++;
   endtask

   task automatic test_zero_len();
      wr_log.delete();
      do_start();
      send_byte(8'h00);
      send_byte(8'h00);
      n_total++;
      if ({busy, wr_en} !== 2'b10)
         $display("FAIL zero_in_csum: busy=%0b we=%0b required 1/0", busy, wr_en);
      else n_pass++;
      send_byte(8'h00);
      n_total++;
      if ({done, error, busy, byte_count, 32'(wr_log.size())} !== {3'b100, 16'd0, 32'd0})
         $display("FAIL zero_done: done=%0b err=%0b busy=%0b cnt=%0d writes=%0d required 1/0/0/0/0",
                  done, error, busy, byte_count, wr_log.size());
      else n_pass++;
      // bytes offered while not ready have no effect
      in_valid = 1'b1; in_data = 8'h5A;
      repeat (3) tick();
      in_valid = 1'b0;
      n_total++;
      if ({done, busy, in_ready, byte_count, 32'(wr_log.size())} !== {3'b100, 16'd0, 32'd0})
         $display("FAIL idle_valid_ignored: done=%0b busy=%0b rdy=%0b cnt=%0d writes=%0d required 1/0/0/0/0",
                  done, busy, in_ready, byte_count, wr_log.size());
      else n_pass++;
   endtask

   task automatic test_full_len();
      int         late = 0;
      int         bad  = 0;
      logic [7:0] sum  = 8'h00;
      wr_log.delete();
      do_start();
      send_byte(8'h80);
      send_byte(8'h00);
      for (int k = 0; k < 32768; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
         end
         send_byte(8'(k));
         sum = sum + 8'(k);
         if (!wr_en || wr_addr !== 15'(k)) late++;
      end
      n_total++;
      if (late != 0)
         $display("FAIL full_latency: late_or_misplaced=%0d required 0", late);
      else n_pass++;
      send_byte(8'h00 - sum);
      for (int i = 0; i < wr_log.size(); i++)
         if (wr_log[i] !== {15'(i), 8'(i)}) bad++;
      n_total++;
      if (wr_log.size() != 32768 || bad != 0)
         $display("FAIL full_sequence: writes=%0d bad=%0d required 32768/0", wr_log.size(), bad);
      else n_pass++;
      n_total++;
      if ({done, error, busy, wr_addr, byte_count} !== {3'b100, 15'h7FFF, 16'h8000})
         $display("FAIL full_done: done=%0b err=%0b busy=%0b addr=%h cnt=%h required 1/0/0/7fff/8000",
                  done, error, busy, wr_addr, byte_count);
      else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      wr_log.delete();
      do_start();
      send_byte(8'h00);
      send_byte(8'h0A);
      for (int k = 0; k < 5; k++) send_byte(8'(k + 8'h40));
      in_valid = 1'b1; in_data = 8'h45;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({in_ready, wr_en, wr_addr, wr_data, rom_hold, busy, done, error, byte_count} !== 45'd0)
         $display("FAIL midload_reset: rdy=%0b we=%0b a=%h d=%h hold=%0b busy=%0b cnt=%0d required all 0",
                  in_ready, wr_en, wr_addr, wr_data, rom_hold, busy, byte_count);
      else n_pass++;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      wr_log.delete();
      do_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'h56);
      n_total++;
      if ({done, error, byte_count, 32'(wr_log.size())} !== {2'b10, 16'd1, 32'd1} || wr_log[0] !== {15'd0, 8'hAA})
         $display("FAIL after_reset_load: done=%0b err=%0b cnt=%0d writes=%0d required 1/0/1/1 at 0000/aa",
                  done, error, byte_count, wr_log.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_bad_len();
      test_zero_len();
      test_full_len();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
